// File: rtl/soft_reset_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | soft_reset_pkg: shared types and constants for the soft reset controller.   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
package soft_reset_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    localparam logic [7:0]  c_key_default         = 8'hA5;
    localparam int unsigned c_hold_cycles_default = 16;
    localparam int unsigned c_drain_max_default   = 255;
    localparam int unsigned c_hold_cnt_w          = $clog2(c_hold_cycles_default);
    localparam int unsigned c_drain_cnt_w         = $clog2(c_drain_max_default);

    // Width of a counter that must hold 0 .. max_val-1; never narrower than 1 bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/soft_reset_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | soft_reset_ctrl: internal reset generator combining rst_n with a keyed      |
// | firmware soft reset that first drains in-flight QSPI traffic. Rev 1.0       |
// +----------------------------------------------------------------------------+
module soft_reset_ctrl
    import soft_reset_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = c_hold_cycles_default,
    parameter int unsigned DRAIN_MAX   = c_drain_max_default,
    parameter logic [7:0]  KEY         = c_key_default
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mmio_wr,
    input  logic [7:0] mmio_wdata,
    input  logic       qspi_busy,
    output logic       rst_out_n,
    output logic       cfg_sample,
    output logic       soft_flag,
    output logic       drain_timeout,
    output logic [7:0] soft_count
);

    localparam int unsigned c_hold_w  = cnt_width(HOLD_CYCLES);
    localparam int unsigned c_drain_w = cnt_width(DRAIN_MAX);

    localparam logic [c_hold_w-1:0]  c_hold_reload = c_hold_w'(HOLD_CYCLES - 1);
    localparam logic [c_drain_w-1:0] c_drain_last  = c_drain_w'(DRAIN_MAX - 1);

    state_t               state_q, state_d;
    logic [c_hold_w-1:0]  hold_cnt_q, hold_cnt_d;
    logic [c_drain_w-1:0] drain_cnt_q, drain_cnt_d;
    logic                 rst_out_n_q, rst_out_n_d;
    logic                 cfg_sample_q, cfg_sample_d;
    logic                 soft_flag_q, soft_flag_d;
    logic                 drain_timeout_q, drain_timeout_d;
    logic [7:0]           soft_count_q, soft_count_d;

    always_comb begin
        state_d         = state_q;
        hold_cnt_d      = hold_cnt_q;
        drain_cnt_d     = drain_cnt_q;
        soft_flag_d     = soft_flag_q;
        drain_timeout_d = drain_timeout_q;
        soft_count_d    = soft_count_q;

        case (state_q)
            ST_IDLE: begin
                if (mmio_wr && (mmio_wdata == KEY)) begin
                    state_d     = ST_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (!qspi_busy || (drain_cnt_q == c_drain_last)) begin
                    state_d      = ST_HOLD;
                    hold_cnt_d   = c_hold_reload;
                    soft_flag_d  = 1'b1;
                    soft_count_d = (soft_count_q == 8'hFF) ? soft_count_q : soft_count_q + 8'd1;
                    // Reaching here with busy still high means the drain gave up.
                    if (qspi_busy) begin
                        drain_timeout_d = 1'b1;
                    end
                end else begin
                    drain_cnt_d = drain_cnt_q + c_drain_w'(1);
                end
            end
            ST_HOLD: begin
                if (hold_cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q - c_hold_w'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next-state view so they line up with the state.
        rst_out_n_d  = (state_d != ST_HOLD);
        cfg_sample_d = (state_d == ST_HOLD) && (hold_cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q         <= ST_HOLD;
            hold_cnt_q      <= c_hold_reload;
            drain_cnt_q     <= '0;
            rst_out_n_q     <= 1'b0;
            cfg_sample_q    <= 1'b0;
            soft_flag_q     <= 1'b0;
            drain_timeout_q <= 1'b0;
            soft_count_q    <= 8'd0;
        end else begin
            state_q         <= state_d;
            hold_cnt_q      <= hold_cnt_d;
            drain_cnt_q     <= drain_cnt_d;
            rst_out_n_q     <= rst_out_n_d;
            cfg_sample_q    <= cfg_sample_d;
            soft_flag_q     <= soft_flag_d;
            drain_timeout_q <= drain_timeout_d;
            soft_count_q    <= soft_count_d;
        end
    end

    assign rst_out_n     = rst_out_n_q;
    assign cfg_sample    = cfg_sample_q;
    assign soft_flag     = soft_flag_q;
    assign drain_timeout = drain_timeout_q;
    assign soft_count    = soft_count_q;

endmodule
`default_nettype wire

// File: tb/tb_soft_reset_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_soft_reset_ctrl: self-checking bench for soft_reset_ctrl.                |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
module tb_soft_reset_ctrl;

    localparam int         HC  = 16;
    localparam int         DM  = 255;
    localparam logic [7:0] KEY = 8'hA5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mmio_wr;
    logic [7:0] mmio_wdata;
    logic       qspi_busy;
    logic       rst_out_n;
    logic       cfg_sample;
    logic       soft_flag;
    logic       drain_timeout;
    logic [7:0] soft_count;

    int checks   = 0;
    int failures = 0;

    // Expected sticky state, updated from the rules of each reset event.
    int m_count;
    int m_flag;
    int m_to;

    soft_reset_ctrl #(
        .HOLD_CYCLES (HC),
        .DRAIN_MAX   (DM),
        .KEY         (KEY)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mmio_wr       (mmio_wr),
        .mmio_wdata    (mmio_wdata),
        .qspi_busy     (qspi_busy),
        .rst_out_n     (rst_out_n),
        .cfg_sample    (cfg_sample),
        .soft_flag     (soft_flag),
        .drain_timeout (drain_timeout),
        .soft_count    (soft_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_sticky(input string tag);
        check({tag, ".soft_flag"},     32'(soft_flag),     32'(m_flag));
        check({tag, ".drain_timeout"}, 32'(drain_timeout), 32'(m_to));
        check({tag, ".soft_count"},    32'(soft_count),    32'(m_count));
    endtask

    // Hold rst_n low (with KEY writes that must lose), then release at edge R and
    // expect rst_out_n low after edges R..R+HC-2, cfg_sample only after R+HC-2.
    task automatic hard_reset(input int low_cycles);
        rst_n = 1'b0;
        for (int i = 0; i < low_cycles; i++) begin
            mmio_wr    = 1'($urandom_range(0, 1));
            mmio_wdata = KEY;
            qspi_busy  = 1'($urandom_range(0, 1));
            step();
            m_count = 0;
            m_flag  = 0;
            m_to    = 0;
            check("rst.rst_out_n",  32'(rst_out_n),  32'd0);
            check("rst.cfg_sample", 32'(cfg_sample), 32'd0);
            check_sticky("rst");
        end
        rst_n = 1'b1;
        for (int k = 0; k < HC; k++) begin
            qspi_busy  = 1'($urandom_range(0, 1));
            mmio_wr    = (k < HC - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            mmio_wdata = KEY;
            step();
            check("hard.rst_out_n",  32'(rst_out_n),  (k <= HC - 2) ? 32'd0 : 32'd1);
            check("hard.cfg_sample", 32'(cfg_sample), (k == HC - 2) ? 32'd1 : 32'd0);
        end
        mmio_wr   = 1'b0;
        qspi_busy = 1'b0;
        check_sticky("hard");
    endtask

    // Writes in IDLE that must not start anything.
    task automatic idle_write(input logic [7:0] data);
        mmio_wr    = 1'b1;
        mmio_wdata = data;
        qspi_busy  = 1'($urandom_range(0, 1));
        step();
        mmio_wr = 1'b0;
        step();
        check("idle.rst_out_n",  32'(rst_out_n),  32'd1);
        check("idle.cfg_sample", 32'(cfg_sample), 32'd0);
        check_sticky("idle");
    endtask

    // One soft reset; busy is high for the first b DRAIN samples. HOLD begins
    // dl edges after the write edge, then rst_out_n stays low for HC cycles.
    task automatic do_soft(input int b, input bit spam);
        int dl;
        int to;
        dl = (b >= DM) ? DM : b + 1;
        to = (b >= DM) ? 1 : 0;
        mmio_wr    = 1'b1;
        mmio_wdata = KEY;
        qspi_busy  = 1'b0;
        step();
        for (int k = 1; k <= dl + HC; k++) begin
            if (k <= dl) qspi_busy = (k <= b);
            else         qspi_busy = 1'($urandom_range(0, 1));
            if (spam && (k < dl + HC)) begin
                mmio_wr    = 1'($urandom_range(0, 1));
                mmio_wdata = ($urandom_range(0, 1) == 1) ? KEY : 8'($urandom);
            end else begin
                mmio_wr = 1'b0;
            end
            step();
            if (k == dl) begin
                m_flag = 1;
                if (m_count < 255) m_count++;
                if (to == 1) m_to = 1;
                check_sticky("soft.entry");
            end
            check("soft.rst_out_n",  32'(rst_out_n),  (k >= dl && k < dl + HC) ? 32'd0 : 32'd1);
            check("soft.cfg_sample", 32'(cfg_sample), (k == dl + HC - 1) ? 32'd1 : 32'd0);
        end
        mmio_wr   = 1'b0;
        qspi_busy = 1'b0;
        check_sticky("soft.exit");
    endtask

    initial begin
        rst_n      = 1'b0;
        mmio_wr    = 1'b0;
        mmio_wdata = 8'h00;
        qspi_busy  = 1'b0;
        m_count    = 0;
        m_flag     = 0;
        m_to       = 0;

        hard_reset(3);

        idle_write(8'h5A);
        idle_write(8'hA4);
        for (int i = 0; i < 6; i++) begin
            logic [7:0] d;
            d = 8'($urandom);
            if (d == KEY) d = d ^ 8'h01;
            idle_write(d);
        end

        do_soft(0, 1'b0);
        do_soft(10, 1'b0);
        do_soft(DM, 1'b0);

        hard_reset(2);
        for (int i = 0; i < 3; i++) do_soft(int'($urandom_range(0, 5)), 1'b1);
        check("three.soft_count", 32'(soft_count), 32'd3);

        // rst_n pulse in the middle of HOLD.
        mmio_wr    = 1'b1;
        mmio_wdata = KEY;
        step();
        mmio_wr = 1'b0;
        repeat (6) step();
        check("midhold.rst_out_n", 32'(rst_out_n), 32'd0);
        hard_reset(1);

        // rst_n pulse in the middle of DRAIN.
        mmio_wr    = 1'b1;
        mmio_wdata = KEY;
        step();
        mmio_wr   = 1'b0;
        qspi_busy = 1'b1;
        repeat (20) step();
        check("middrain.rst_out_n", 32'(rst_out_n), 32'd1);
        hard_reset(2);

        do_soft(0, 1'b1);
        check("spam.soft_count", 32'(soft_count), 32'd1);

        for (int i = 0; i < 255; i++) do_soft(int'($urandom_range(0, 3)), 1'b1);
        check("sat.soft_count", 32'(soft_count), 32'd255);
        idle_write(8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
